// File: rtl/cache_line_fill.sv
// -----------------------------------------------------------------------------
// cache_line_fill
//
// Cache line fill engine. It accepts one line-fill request, then consumes
// exactly LINE_WORDS memory beats and writes each beat into a word-wide SRAM
// through a registered write port. One write is issued per beat, in the cycle
// after that beat is accepted. A one-cycle done_o pulse coincides with the
// final SRAM write. The engine also reports framing errors on mem_last_i
// through a sticky err_o flag.
//
// Parameters
//   DATA_WIDTH  beat / SRAM word width
//   N_ENTRIES   SRAM depth in words (AW = $clog2(N_ENTRIES))
//   LINE_WORDS  words per line, a power of two >= 2 (OW = $clog2(LINE_WORDS))
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   req_valid_i/req_ready_o  line-fill request handshake (ready only when idle)
//   req_addr_i               SRAM word index of the line; low OW bits ignored
//   req_word_i               critical word offset (critical-word-first only)
//   mem_valid_i/mem_ready_o  memory beat handshake (ready only while filling)
//   mem_data_i, mem_last_i   beat data and final-beat marker
//   sram_en_o, sram_we_o     SRAM enable / write enable (one cycle per beat)
//   sram_addr_o, sram_data_o SRAM write address / data (hold between writes)
//   done_o                   one-cycle pulse in the cycle of the final write
//   err_o                    sticky framing error, cleared by the next request
//
// Configuration macro
//   LINE_FILL_CRIT_FIRST_EN  when defined, the first beat is written to offset
//                            req_word_i and later beats wrap modulo LINE_WORDS.
//                            When undefined, beats start at offset 0 and
//                            req_word_i is ignored.
// -----------------------------------------------------------------------------
module cache_line_fill #(
   parameter int unsigned  DATA_WIDTH = 32,
   parameter int unsigned  N_ENTRIES  = 1024,
   parameter int unsigned  LINE_WORDS = 8,
   localparam int unsigned AW         = $clog2(N_ENTRIES),
   localparam int unsigned OW         = $clog2(LINE_WORDS)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   // Line-fill request
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [AW-1:0]         req_addr_i,
   input  logic [OW-1:0]         req_word_i,
   // Memory beats
   input  logic                  mem_valid_i,
   output logic                  mem_ready_o,
   input  logic [DATA_WIDTH-1:0] mem_data_i,
   input  logic                  mem_last_i,
   // SRAM write port
   output logic                  sram_en_o,
   output logic                  sram_we_o,
   output logic [AW-1:0]         sram_addr_o,
   output logic [DATA_WIDTH-1:0] sram_data_o,
   // Status
   output logic                  done_o,
   output logic                  err_o
);

   // Beat counter value while the final beat of the line is on the bus.
   localparam logic [OW:0] LastBeat = (OW + 1)'(LINE_WORDS - 1);

   typedef enum logic [1:0] {
      StIdle,
      StFill,
      StDone
   } state_e;

   state_e                  state_q, state_d;

   // Handshake readies are registered so that reset can hold them low even
   // though the FSM itself sits in StIdle during reset.
   logic                    req_ready_q, req_ready_d;
   logic                    mem_ready_q, mem_ready_d;

   logic [AW-1:0]           base_q, base_d;
   logic [OW-1:0]           offset_q, offset_d;
   logic [OW:0]             beat_cnt_q, beat_cnt_d;
   logic                    err_q, err_d;

   // One flop drives both sram_en_o and sram_we_o: this port only writes.
   logic                    sram_wr_q, sram_wr_d;
   logic [AW-1:0]           sram_addr_q, sram_addr_d;
   logic [DATA_WIDTH-1:0]   sram_data_q, sram_data_d;

   logic                    req_fire;
   logic                    beat_fire;
   logic                    last_beat;
   logic [OW-1:0]           first_offset;

   // Offset of the first beat of a new line.
`ifdef LINE_FILL_CRIT_FIRST_EN
   assign first_offset = req_word_i;
`else
   assign first_offset = '0;
`endif

   // Low address bits are replaced by the line base; req_word_i is only
   // consumed in the critical-word-first build.
   logic unused_inputs;
   assign unused_inputs = ^{req_addr_i[OW-1:0], req_word_i};

   assign req_fire  = req_valid_i && req_ready_q;
   assign beat_fire = mem_valid_i && mem_ready_q;
   assign last_beat = (beat_cnt_q == LastBeat);

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      offset_d    = offset_q;
      beat_cnt_d  = beat_cnt_q;
      err_d       = err_q;
      sram_wr_d   = 1'b0;
      sram_addr_d = sram_addr_q;
      sram_data_d = sram_data_q;

      case (state_q)
         StIdle: begin
            if (req_fire) begin
               state_d    = StFill;
               base_d     = {req_addr_i[AW-1:OW], {OW{1'b0}}};
               offset_d   = first_offset;
               beat_cnt_d = '0;
               err_d      = 1'b0;
            end
         end

         StFill: begin
            if (beat_fire) begin
               sram_wr_d   = 1'b1;
               sram_addr_d = base_q | AW'(offset_q);
               sram_data_d = mem_data_i;
               // Offset wraps naturally at the OW-bit boundary.
               offset_d    = offset_q + OW'(1);
               beat_cnt_d  = beat_cnt_q + (OW + 1)'(1);
               // Framing error: last flagged early, or missing on the final beat.
               // It never changes the beat count of the fill.
               if (mem_last_i != last_beat) begin
                  err_d = 1'b1;
               end
               if (last_beat) begin
                  state_d = StDone;
               end
            end
         end

         StDone: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase

      // Readies follow the state being entered, so they are valid in the
      // same cycle the state is.
      req_ready_d = (state_d == StIdle);
      mem_ready_d = (state_d == StFill);
   end

   // --------------------------------------------------------------------------
   // State registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         req_ready_q <= 1'b0;
         mem_ready_q <= 1'b0;
         base_q      <= '0;
         offset_q    <= '0;
         beat_cnt_q  <= '0;
         err_q       <= 1'b0;
         sram_wr_q   <= 1'b0;
         sram_addr_q <= '0;
         sram_data_q <= '0;
      end else begin
         state_q     <= state_d;
         req_ready_q <= req_ready_d;
         mem_ready_q <= mem_ready_d;
         base_q      <= base_d;
         offset_q    <= offset_d;
         beat_cnt_q  <= beat_cnt_d;
         err_q       <= err_d;
         sram_wr_q   <= sram_wr_d;
         sram_addr_q <= sram_addr_d;
         sram_data_q <= sram_data_d;
      end
   end

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   assign req_ready_o = req_ready_q;
   assign mem_ready_o = mem_ready_q;
   assign sram_en_o   = sram_wr_q;
   assign sram_we_o   = sram_wr_q;
   assign sram_addr_o = sram_addr_q;
   assign sram_data_o = sram_data_q;
   // StDone is entered on the edge that registers the final write, so the
   // pulse lines up with that write on the ports.
   assign done_o      = (state_q == StDone);
   assign err_o       = err_q;

   // --------------------------------------------------------------------------
   // Properties
   // --------------------------------------------------------------------------
   // The two handshakes are never open at the same time.
   a_ready_exclusive: assert property (
      @(posedge clk_i) disable iff (!rst_ni) !(req_ready_o && mem_ready_o));

   // done_o always carries the final write of the line.
   a_done_with_write: assert property (
      @(posedge clk_i) disable iff (!rst_ni) done_o |-> sram_en_o);

   // A beat is only accepted while filling.
   a_fill_only: assert property (
      @(posedge clk_i) disable iff (!rst_ni) beat_fire |-> (state_q == StFill));

endmodule
